// File: rtl/sequencer_ctrl_v2.sv
// sequencer_ctrl_v2: slot sequencer running an IRAM program with registers, CALC, BRN, waits and a daisy-chained load bus
module sequencer_ctrl_v2 #(
  parameter int NUM_SLOTS = 16,
  parameter int FSM_PER_SLOT = 4,
  parameter int IRAM_DEPTH = 64,
  parameter int NUM_REGS = 16,
  parameter int REG_W = 16,
  parameter int RESOURCE_INSTR_WIDTH = 27,
  parameter int INSTR_HOPS_WIDTH = 4,
  localparam int IRAM_AW = $clog2(IRAM_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              call,
  output logic                              ret,
  output logic                              busy,
  output logic [NUM_SLOTS-1:0]              instr_valid,
  output logic [RESOURCE_INSTR_WIDTH-1:0]   instr,
  output logic [NUM_SLOTS*FSM_PER_SLOT-1:0] activate,
  input  logic [31:0]                       instr_load_data_in,
  output logic [31:0]                       instr_load_data_out,
  input  logic [IRAM_AW-1:0]                instr_load_addr_in,
  output logic [IRAM_AW-1:0]                instr_load_addr_out,
  input  logic [INSTR_HOPS_WIDTH-1:0]       instr_load_hops_in,
  output logic [INSTR_HOPS_WIDTH-1:0]       instr_load_hops_out,
  input  logic                              instr_load_en_in,
  output logic                              instr_load_en_out
);
  localparam int ACT_W = NUM_SLOTS * FSM_PER_SLOT;
  localparam int CNT_W = REG_W > 27 ? REG_W : 27;
  typedef enum logic [1:0] {IDLE, DECODE, WAIT} state_t;
  state_t state_q, state_d;
  logic [IRAM_AW-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, n;
  logic [REG_W-1:0] regs_q [16];
  logic [REG_W-1:0] regs_d [16];
  logic [31:0] iram_q [IRAM_DEPTH];
  logic [31:0] iram_d [IRAM_DEPTH];
  logic [31:0] w;
  logic [REG_W-1:0] a, b, alu;
  logic [5:0] m;
  logic [31:0] ld_data_q, ld_data_d;
  logic [IRAM_AW-1:0] ld_addr_q, ld_addr_d;
  logic [INSTR_HOPS_WIDTH-1:0] ld_hops_q, ld_hops_d;
  logic ld_en_q, ld_en_d;
  assign busy = state_q != IDLE;
  assign instr_load_data_out = ld_data_q;
  assign instr_load_addr_out = ld_addr_q;
  assign instr_load_hops_out = ld_hops_q;
  assign instr_load_en_out = ld_en_q;
  // decode the word at pc: next state, pc, wait counter, register writes and strobes
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    cnt_d = cnt_q;
    regs_d = regs_q;
    ret = 1'b0;
    instr_valid = '0;
    instr = '0;
    activate = '0;
    w = iram_q[pc_q];
    a = regs_q[w[21:18]];
    b = w[17] ? regs_q[w[12:9]] : REG_W'(w[16:9]);
    m = w[27:22];
    alu = m == 6'd0 ? a + b : m == 6'd1 ? a - b : m == 6'd2 ? b : m == 6'd3 ? a & b :
          m == 6'd4 ? a | b : m == 6'd5 ? a << b[3:0] : a >> b[3:0];
    n = w[27] ? CNT_W'(regs_q[w[3:0]]) : CNT_W'(w[26:0]);
    case (state_q)
      IDLE: begin
        if (call) begin
          state_d = DECODE;
          pc_d = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DECODE;
          pc_d = pc_q + 1'b1;
        end
      end
      default: begin
        pc_d = pc_q + 1'b1;
        if (w[31]) begin
          instr = RESOURCE_INSTR_WIDTH'({w[30:28], w[23:0]});
          instr_valid = NUM_SLOTS'(16'b1 << w[27:24]);
        end else begin
          case (w[30:28])
            3'd0: begin
              ret = 1'b1;
              state_d = IDLE;
              pc_d = '0;
            end
            3'd1: begin
              if (n != '0) begin
                pc_d = pc_q;
                state_d = WAIT;
                cnt_d = n;
              end
            end
            3'd2: activate = ACT_W'(w[27:12]) << (32'(w[7:0]) * FSM_PER_SLOT);
            3'd3: begin
              if (m <= 6'd6 && {1'b0, w[8:5]} < 5'(NUM_REGS)) regs_d[w[8:5]] = alu;
            end
            3'd4: pc_d = regs_q[w[27:24]] != '0 ? w[15+:IRAM_AW] : w[6+:IRAM_AW];
            default: ;
          endcase
        end
      end
    endcase
  end
  // load chain: write locally when hops reach zero, otherwise forward one hop further
  always_comb begin
    iram_d = iram_q;
    ld_en_d = instr_load_en_in && instr_load_hops_in != '0;
    ld_data_d = ld_en_d ? instr_load_data_in : '0;
    ld_addr_d = ld_en_d ? instr_load_addr_in : '0;
    ld_hops_d = ld_en_d ? instr_load_hops_in - 1'b1 : '0;
    if (instr_load_en_in && instr_load_hops_in == '0) iram_d[instr_load_addr_in] = instr_load_data_in;
  end
  // state, register file, IRAM and load-chain registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= '0;
      cnt_q <= '0;
      regs_q <= '{default: '0};
      iram_q <= '{default: '0};
      ld_data_q <= '0;
      ld_addr_q <= '0;
      ld_hops_q <= '0;
      ld_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      regs_q <= regs_d;
      iram_q <= iram_d;
      ld_data_q <= ld_data_d;
      ld_addr_q <= ld_addr_d;
      ld_hops_q <= ld_hops_d;
      ld_en_q <= ld_en_d;
    end
  end
endmodule
